// File: rtl/btn_evt_pkg.sv
// Shared types for the button event scheduler.
// Event kind codes and the per-button timer state encoding.
package btn_evt_pkg;

  localparam logic [1:0] KIND_PRESS   = 2'd0;
  localparam logic [1:0] KIND_RELEASE = 2'd1;
  localparam logic [1:0] KIND_LONG    = 2'd2;
  localparam logic [1:0] KIND_REPEAT  = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HELD = 2'd1,
    ST_RPT  = 2'd2
  } tmr_state_e;

endpackage

// File: rtl/button_event_scheduler_if.sv
// Event channel between the scheduler and its consumer.
// master: evt_valid/evt_id/evt_kind/evt_drop out, evt_ready in.
interface button_event_scheduler_if #(
  parameter int N_BTN = 4
) ();
  localparam int ID_W = $clog2(N_BTN);

  logic            evt_valid;
  logic            evt_ready;
  logic [ID_W-1:0] evt_id;
  logic [1:0]      evt_kind;
  logic            evt_drop;

  modport master (
    output evt_valid,
    output evt_id,
    output evt_kind,
    output evt_drop,
    input  evt_ready
  );

  modport slave (
    input  evt_valid,
    input  evt_id,
    input  evt_kind,
    input  evt_drop,
    output evt_ready
  );
endinterface

// File: rtl/button_hold_timer.sv
// Per-button edge detect and hold timer (IDLE/HELD/RPT).
// Ports: clk, rst, btn level in; evt_stb 1-cycle strobe, evt_kind.
module button_hold_timer
  import btn_evt_pkg::*;
#(
  parameter int               CTR_W      = 24,
  parameter logic [CTR_W-1:0] LONG_CYC   = CTR_W'(5_000_000),
  parameter logic [CTR_W-1:0] REPEAT_CYC = CTR_W'(1_000_000)
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn,
  output logic       evt_stb,
  output logic [1:0] evt_kind
);

  tmr_state_e       st_q, st_d;
  logic [CTR_W-1:0] cnt_q, cnt_d;
  logic             prev_q;
  logic             rise, fall;

  assign rise = btn & ~prev_q;
  assign fall = ~btn & prev_q;

  // Strobe is combinational from the edge so the
  // pending slot captures it on the next clock.
  always_comb begin
    st_d     = st_q;
    cnt_d    = cnt_q;
    evt_stb  = 1'b0;
    evt_kind = KIND_PRESS;
    unique case (st_q)
      ST_IDLE: begin
        if (rise) begin
          evt_stb  = 1'b1;
          evt_kind = KIND_PRESS;
          st_d     = ST_HELD;
          cnt_d    = '0;
        end
      end
      ST_HELD: begin
        if (fall) begin
          evt_stb  = 1'b1;
          evt_kind = KIND_RELEASE;
          st_d     = ST_IDLE;
          cnt_d    = '0;
        end else if (cnt_q == LONG_CYC - 1'b1) begin
          evt_stb  = 1'b1;
          evt_kind = KIND_LONG;
          st_d     = ST_RPT;
          cnt_d    = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_RPT: begin
        if (fall) begin
          evt_stb  = 1'b1;
          evt_kind = KIND_RELEASE;
          st_d     = ST_IDLE;
          cnt_d    = '0;
        end else if (cnt_q == REPEAT_CYC - 1'b1) begin
          evt_stb  = 1'b1;
          evt_kind = KIND_REPEAT;
          cnt_d    = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        st_d  = ST_IDLE;
        cnt_d = '0;
      end
    endcase
  end

  // prev follows btn during reset: a button held
  // through reset produces no PRESS.
  always_ff @(posedge clk) begin
    prev_q <= btn;
    if (rst) begin
      st_q  <= ST_IDLE;
      cnt_q <= '0;
    end else begin
      st_q  <= st_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/button_event_scheduler.sv
// Turns debounced button levels into PRESS/RELEASE/LONG/REPEAT events.
// Ports: clk, rst, btn_db[N_BTN]; evt_if master (valid/ready/id/kind/drop).
module button_event_scheduler
  import btn_evt_pkg::*;
#(
  parameter int               N_BTN      = 4,
  parameter int               CTR_W      = 24,
  parameter logic [CTR_W-1:0] LONG_CYC   = CTR_W'(5_000_000),
  parameter logic [CTR_W-1:0] REPEAT_CYC = CTR_W'(1_000_000)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_BTN-1:0]         btn_db,
  button_event_scheduler_if.master evt_if
);

  localparam int ID_W = $clog2(N_BTN);

  logic [N_BTN-1:0]      stb;
  logic [N_BTN-1:0][1:0] stb_kind;

  for (genvar g = 0; g < N_BTN; g++) begin : g_tmr
    button_hold_timer #(
      .CTR_W      (CTR_W),
      .LONG_CYC   (LONG_CYC),
      .REPEAT_CYC (REPEAT_CYC)
    ) u_tmr (
      .clk      (clk),
      .rst      (rst),
      .btn      (btn_db[g]),
      .evt_stb  (stb[g]),
      .evt_kind (stb_kind[g])
    );
  end

  logic [N_BTN-1:0]      pend_v_q, pend_v_d;
  logic [N_BTN-1:0][1:0] pend_k_q, pend_k_d;
  logic [ID_W-1:0]       ptr_q, ptr_d;
  logic                  out_v_q, out_v_d;
  logic [ID_W-1:0]       out_id_q, out_id_d;
  logic [1:0]            out_kind_q, out_kind_d;
  logic                  drop_q, drop_d;

  logic                  out_load;
  logic                  found;
  logic [ID_W-1:0]       sel;
  logic [N_BTN-1:0]      grant;

  // Round-robin pick: first pending slot from ptr.
  always_comb begin
    int idx;
    idx   = 0;
    found = 1'b0;
    sel   = '0;
    for (int k = 0; k < N_BTN; k++) begin
      idx = (int'(ptr_q) + k) % N_BTN;
      if (!found && pend_v_q[idx]) begin
        found = 1'b1;
        sel   = ID_W'(idx);
      end
    end
  end

  // Output reg refills when empty or draining now.
  assign out_load = ~out_v_q | evt_if.evt_ready;

  always_comb begin
    grant = '0;
    if (out_load && found) grant[sel] = 1'b1;
  end

  // A fresh event in a still-occupied slot that is
  // not leaving this cycle overwrites it.
  always_comb begin
    pend_v_d = pend_v_q & ~grant;
    pend_k_d = pend_k_q;
    drop_d   = 1'b0;
    for (int i = 0; i < N_BTN; i++) begin
      if (stb[i]) begin
        if (pend_v_q[i] && !grant[i]) drop_d = 1'b1;
        pend_v_d[i] = 1'b1;
        pend_k_d[i] = stb_kind[i];
      end
    end
  end

  always_comb begin
    out_v_d    = out_v_q;
    out_id_d   = out_id_q;
    out_kind_d = out_kind_q;
    ptr_d      = ptr_q;
    if (out_load) begin
      out_v_d = found;
      if (found) begin
        out_id_d   = sel;
        out_kind_d = pend_k_q[sel];
        ptr_d      = ID_W'((int'(sel) + 1) % N_BTN);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pend_v_q   <= '0;
      pend_k_q   <= '0;
      ptr_q      <= '0;
      out_v_q    <= 1'b0;
      out_id_q   <= '0;
      out_kind_q <= '0;
      drop_q     <= 1'b0;
    end else begin
      pend_v_q   <= pend_v_d;
      pend_k_q   <= pend_k_d;
      ptr_q      <= ptr_d;
      out_v_q    <= out_v_d;
      out_id_q   <= out_id_d;
      out_kind_q <= out_kind_d;
      drop_q     <= drop_d;
    end
  end

  assign evt_if.evt_valid = out_v_q;
  assign evt_if.evt_id    = out_id_q;
  assign evt_if.evt_kind  = out_kind_q;
  assign evt_if.evt_drop  = drop_q;

endmodule

// File: tb/tb_button_event_scheduler.sv
// Scoreboard bench for button_event_scheduler.
// N_BTN=4, LONG_CYC=8, REPEAT_CYC=4; directed scenarios.
module tb_button_event_scheduler;
  import btn_evt_pkg::*;

  localparam int N = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [N-1:0] btn_db = '0;

  always #5 clk = ~clk;

  button_event_scheduler_if #(.N_BTN(N)) evt_if ();

  button_event_scheduler #(
    .N_BTN      (N),
    .CTR_W      (24),
    .LONG_CYC   (24'd8),
    .REPEAT_CYC (24'd4)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .btn_db (btn_db),
    .evt_if (evt_if)
  );

  typedef struct {
    int id;
    int kind;
    int cyc;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   n_vec = 0;
  int   n_err = 0;
  int   n_drop = 0;

  logic       hold_v = 1'b0;
  logic [1:0] hold_id = '0;
  logic [1:0] hold_kind = '0;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: pops one expected event per accepted
  // transfer; also checks hold stability.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && evt_if.evt_drop) n_drop++;
    if (hold_v) begin
      n_vec++;
      if (!evt_if.evt_valid || evt_if.evt_id != hold_id ||
          evt_if.evt_kind != hold_kind) begin
        n_err++;
        $display("FAIL hold cyc=%0d: got v=%0b id=%0d kind=%0d, required v=1 id=%0d kind=%0d",
                 cyc, evt_if.evt_valid, evt_if.evt_id, evt_if.evt_kind,
                 hold_id, hold_kind);
      end
    end
    hold_v    = evt_if.evt_valid && !evt_if.evt_ready && !rst;
    hold_id   = evt_if.evt_id;
    hold_kind = evt_if.evt_kind;
    if (!rst && evt_if.evt_valid && evt_if.evt_ready) begin
      n_vec++;
      if (sb.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_evt cyc=%0d: got id=%0d kind=%0d, required none",
                 cyc, evt_if.evt_id, evt_if.evt_kind);
      end else begin
        e = sb.pop_front();
        if (int'(evt_if.evt_id) != e.id || int'(evt_if.evt_kind) != e.kind ||
            (e.cyc >= 0 && cyc != e.cyc)) begin
          n_err++;
          $display("FAIL evt: got id=%0d kind=%0d cyc=%0d, required id=%0d kind=%0d cyc=%0d",
                   evt_if.evt_id, evt_if.evt_kind, cyc, e.id, e.kind, e.cyc);
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input int id, input int kind, input int c);
    exp_t e;
    e.id   = id;
    e.kind = kind;
    e.cyc  = c;
    sb.push_back(e);
  endtask

  task automatic chk(input string name, input int got, input int req);
    n_vec++;
    if (got != req) begin
      n_err++;
      $display("FAIL %s: got %0d, required %0d", name, got, req);
    end
  endtask

  initial begin
    int t;
    int t2;
    evt_if.evt_ready = 1'b1;

    // 1: button held through reset -> nothing
    btn_db = 4'b0001;
    rst = 1'b1;
    tick(3);
    chk("rst_valid", int'(evt_if.evt_valid), 0);
    chk("rst_id", int'(evt_if.evt_id), 0);
    chk("rst_kind", int'(evt_if.evt_kind), 0);
    chk("rst_drop", int'(evt_if.evt_drop), 0);
    rst = 1'b0;
    tick(30);
    btn_db = 4'b0000;
    tick(5);
    chk("t1_pending", sb.size(), 0);
    chk("t1_drops", n_drop, 0);

    // 2: short press on button 0
    t = cyc;
    btn_db[0] = 1'b1;
    push(0, KIND_PRESS, t + 2);
    tick(3);
    btn_db[0] = 1'b0;
    push(0, KIND_RELEASE, t + 5);
    tick(6);
    chk("t2_pending", sb.size(), 0);

    // 3: long hold on button 1; fall coincides with a REPEAT
    t = cyc;
    btn_db[1] = 1'b1;
    push(1, KIND_PRESS, t + 2);
    push(1, KIND_LONG, t + 10);
    push(1, KIND_REPEAT, t + 14);
    push(1, KIND_REPEAT, t + 18);
    tick(20);
    btn_db[1] = 1'b0;
    push(1, KIND_RELEASE, t + 22);
    tick(6);
    chk("t3_pending", sb.size(), 0);
    chk("t3_drops", n_drop, 0);

    // 4: simultaneous edges, round-robin order (ptr reset to 0)
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    tick(2);
    t = cyc;
    btn_db = 4'b0101;
    push(0, KIND_PRESS, t + 2);
    push(2, KIND_PRESS, t + 3);
    tick(4);
    t2 = cyc;
    btn_db = 4'b0000;
    push(0, KIND_RELEASE, t2 + 2);
    push(2, KIND_RELEASE, t2 + 3);
    tick(4);
    t = cyc;
    btn_db = 4'b1001;
    push(3, KIND_PRESS, t + 2);
    push(0, KIND_PRESS, t + 3);
    tick(4);
    t2 = cyc;
    btn_db = 4'b0000;
    push(3, KIND_RELEASE, t2 + 2);
    push(0, KIND_RELEASE, t2 + 3);
    tick(4);
    chk("t4_pending", sb.size(), 0);
    chk("t4_drops", n_drop, 0);

    // 5: backpressure, pending RELEASE overwritten
    n_drop = 0;
    t = cyc;
    evt_if.evt_ready = 1'b0;
    btn_db[0] = 1'b1;
    push(0, KIND_PRESS, t + 8);
    push(0, KIND_PRESS, t + 9);
    tick(2);
    btn_db[0] = 1'b0;
    tick(2);
    btn_db[0] = 1'b1;
    tick(2);
    chk("t5_out_valid", int'(evt_if.evt_valid), 1);
    chk("t5_out_kind", int'(evt_if.evt_kind), int'(KIND_PRESS));
    tick(2);
    evt_if.evt_ready = 1'b1;
    tick(3);
    t2 = cyc;
    btn_db[0] = 1'b0;
    push(0, KIND_RELEASE, t2 + 2);
    tick(4);
    chk("t5_pending", sb.size(), 0);
    chk("t5_drops", n_drop, 1);

    // 6: reset while output full and two slots pending
    n_drop = 0;
    evt_if.evt_ready = 1'b0;
    btn_db = 4'b0110;
    tick(1);
    btn_db = 4'b1110;
    tick(1);
    chk("t6_pre_valid", int'(evt_if.evt_valid), 1);
    rst = 1'b1;
    tick(1);
    chk("t6_post_valid", int'(evt_if.evt_valid), 0);
    chk("t6_post_drop", int'(evt_if.evt_drop), 0);
    rst = 1'b0;
    evt_if.evt_ready = 1'b1;
    tick(10);
    btn_db = 4'b0000;
    tick(5);
    chk("t6_pending", sb.size(), 0);
    chk("t6_drops", n_drop, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
